// File: rtl/pulse_height_analyzer.sv
// Pulse-height analyzer: peak capture, MAX_LEN abort, DEADTIME holdoff, optional PILEUP_REJECT_EN rejection.
// Latency: ch_valid/ch_index are registered and appear the cycle after the clock edge that samples the end-of-pulse sample.
// Backpressure: a single output register holds its event until ch_ready; events that end while it is occupied are dropped and counted.
module pulse_height_analyzer #(
    parameter int ADC_W    = 14,
    parameter int CH_W     = 10,
    parameter int DEADTIME = 16,
    parameter int MAX_LEN  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample,
    input  logic [ADC_W-1:0] threshold,
    output logic             ch_valid,
    input  logic             ch_ready,
    output logic [CH_W-1:0]  ch_index,
    output logic [31:0]      pulse_cnt,
    output logic [31:0]      drop_cnt,
    output logic [31:0]      pileup_cnt
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int HO_W  = $clog2(DEADTIME + 1);
    localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(DEADTIME - 1);

    typedef enum logic [1:0] {IDLE, RISE, HOLDOFF} state_t;

    state_t             state_q, state_d;
    logic [ADC_W-1:0]   thr_l;
    logic [ADC_W-1:0]   peak;
    logic [LEN_W-1:0]   len;
    logic [HO_W-1:0]    ho_cnt;

    logic start;
    logic cont;
    logic pulse_end;
    logic rejected;
    logic emit;
    logic reject_ev;
    logic out_free;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign start = (state_q == IDLE) && sample_valid && (sample > threshold);
    assign cont  = (state_q == RISE) && sample_valid && (sample > thr_l);

    always_comb begin
        state_d   = state_q;
        pulse_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = RISE;
            end
            RISE: begin
                if (sample_valid) begin
                    if (sample <= thr_l) begin
                        state_d   = HOLDOFF;
                        pulse_end = 1'b1;
                    end else if (len >= LEN_LAST) begin
                        // Over-long pulse: abandon without emitting anything.
                        state_d = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (ho_cnt == HO_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PILEUP_REJECT_EN
    logic [ADC_W-1:0] prev;
    logic             fell;
    logic             pu;

    assign rejected = pu;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            fell <= 1'b0;
            pu   <= 1'b0;
        end else if (start) begin
            prev <= sample;
            fell <= 1'b0;
            pu   <= 1'b0;
        end else if (cont) begin
            // A rise after the pulse has already started falling marks a second overlapping pulse.
            if (fell && (sample > prev))
                pu <= 1'b1;
            if (sample < prev)
                fell <= 1'b1;
            prev <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pileup_cnt <= '0;
        else if (reject_ev)
            pileup_cnt <= sat_inc(pileup_cnt);
    end
`else
    assign rejected   = 1'b0;
    assign pileup_cnt = '0;
`endif

    assign emit      = pulse_end && !rejected;
    assign reject_ev = pulse_end && rejected;
    assign out_free  = !ch_valid || ch_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            thr_l   <= '0;
            peak    <= '0;
            len     <= '0;
            ho_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                thr_l <= threshold;
                peak  <= sample;
                len   <= LEN_W'(1);
            end else if (cont) begin
                if (sample > peak)
                    peak <= sample;
                len <= len + 1'b1;
            end
            if (state_q == HOLDOFF)
                ho_cnt <= (ho_cnt == HO_LAST) ? '0 : ho_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_valid  <= 1'b0;
            ch_index  <= '0;
            pulse_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (emit && out_free) begin
                ch_valid  <= 1'b1;
                ch_index  <= peak[ADC_W-1 -: CH_W];
                pulse_cnt <= sat_inc(pulse_cnt);
            end else begin
                if (ch_valid && ch_ready)
                    ch_valid <= 1'b0;
                if (emit)
                    drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule
